nibble_serial_subtractor: RTL
=============================

Name: nibble_serial_subtractor

Overview:
Multi-cycle wide subtractor controller that computes diff = a - b - bin on NIBBLES*4-bit operands by time-sharing one instance of the team's 4-bit borrow-lookahead subtractor slice (ports Diff, Bout, X, Y, Bin). Each cycle it feeds the slice one nibble pair, least significant nibble first, plus the registered borrow. It collects the slice's Diff/Bout back into a result register. It sits between an operand source (register file or testbench driver) and any consumer of the wide difference.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
clk     input   1   system clock; all state changes on rising edge
rst_n   input   1   synchronous reset, active-low
start   input   1   request; sampled only in IDLE
a       input   W   minuend; latched when start is accepted
b       input   W   subtrahend; latched when start is accepted
bin     input   1   borrow-in; latched when start is accepted
busy    output  1   high while a subtraction is in progress (RUN)
done    output  1   one-cycle pulse; result valid
diff    output  W   difference a - b - bin mod 2^W
bout    output  1   final borrow-out (1 when a < b + bin, unsigned)
ovf     output  1   signed (two's-complement) overflow of the subtraction

Behaviour:
- Reset: when rst_n=0 at a rising edge, the block goes to IDLE. It clears busy, done, diff, bout, ovf, the nibble index, the borrow register and the latched operands to 0. Reset overrides start.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 at an edge: latch a, b and bin; set idx=0; set borrow_reg=bin; clear diff, bout and ovf; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1): at each edge, do the following, then increment idx.
  - Drive slice X = a_lat[4*idx+3:4*idx], Y = b_lat nibble idx, Bin = borrow_reg.
  - Write slice Diff into diff[4*idx+3:4*idx].
  - Load borrow_reg from slice Bout.
- RUN exit: on the edge where idx = NIBBLES-1, also do the following, then go to DONE.
  - bout <= slice Bout.
  - ovf <= (a_lat[W-1] != b_lat[W-1]) && (final diff[W-1] != a_lat[W-1]). Use the nibble being written that cycle for bit W-1.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE unconditionally. start is ignored in DONE.
- Timing: if start is accepted at edge k, busy is high after edges k..k+NIBBLES-1. done is high after edge k+NIBBLES (NIBBLES+1 edges from start to done). Next start is accepted at edge k+NIBBLES+2 or later.
- start while busy or in DONE is ignored. Changing a, b or bin during RUN has no effect.
- diff, bout and ovf hold their values after done until the next accepted start, which clears them. Partial diff is visible during RUN and is not guaranteed meaningful.
- idx wraps only via the RUN→DONE transition. idx never exceeds NIBBLES-1, and nibble slices outside 0..NIBBLES-1 are never addressed.
- Reset mid-RUN: abort immediately with all outputs at 0 and no done pulse. The next start behaves as from power-up.
- bin is treated as a borrow into bit 0 only. The result is modulo 2^W.

Test Plan (NIBBLES=4):
1. a=0x1234, b=0x0111, bin=0, pulse start → busy high 4 cycles, done one cycle later; diff=0x1123, bout=0, ovf=0.
2. a=0x0000, b=0x0001, bin=0 → borrow ripples through all nibbles: diff=0xFFFF, bout=1, ovf=0.
3. a=0x8000, b=0x0001, bin=0 → diff=0x7FFF, bout=0, ovf=1. a=0x7FFF, b=0xFFFF, bin=0 → diff=0x8000, bout=1, ovf=1.
4. a=0x0000, b=0xFFFF, bin=1 → diff=0x0000, bout=1, ovf=0. a=0xB5B5, b=0xB5B5, bin=1 → diff=0xFFFF, bout=1.
5. start with a=0x1234, b=0x0111; re-pulse start with a=0xFFFF, b=0 during the 2nd RUN cycle and during DONE → both ignored, diff=0x1123; the next start after IDLE returns is accepted.
6. rst_n=0 for one edge during the 2nd RUN cycle → busy=0, diff=0, bout=0, no done pulse. Then a=0x0005, b=0x0003, bin=0 with start → diff=0x0002, bout=0, done after NIBBLES+1 edges.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_subtractor
// Description : Multi-cycle wide subtractor. It computes diff = a - b - bin
//               on 4*NIBBLES-bit operands. One 4-bit borrow-lookahead slice is
//               reused every cycle, least significant nibble first, and the
//               borrow is registered between nibbles.
// Ports       : clk    - system clock (rising edge)
//               rst_n  - synchronous reset, active-low
//               start  - request, sampled only in IDLE
//               a, b   - minuend / subtrahend, latched on accepted start
//               bin    - borrow into bit 0, latched on accepted start
//               busy   - high while the nibble loop runs
//               done   - one-cycle pulse, result valid
//               diff   - a - b - bin mod 2^W
//               bout   - final borrow-out (unsigned a < b + bin)
//               ovf    - two's-complement overflow
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_subtractor #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] diff,
    output logic                 bout,
    output logic                 ovf
);

    localparam int C_W  = 4 * NIBBLES;
    localparam int C_IW = $clog2(NIBBLES);
    localparam logic [C_IW-1:0] C_LAST = C_IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [C_IW-1:0]   r_idx;
    logic [C_W-1:0]    r_a;
    logic [C_W-1:0]    r_b;
    logic              r_borrow;

    logic [3:0]        w_x;
    logic [3:0]        w_y;
    logic [3:0]        w_sdiff;
    logic              w_sbout;

    // Current nibble pair selected by the loop index.
    assign w_x = r_a[{r_idx, 2'b00} +: 4];
    assign w_y = r_b[{r_idx, 2'b00} +: 4];

    sub4_bla u_slice (
        .Diff (w_sdiff),
        .Bout (w_sbout),
        .X    (w_x),
        .Y    (w_y),
        .Bin  (r_borrow)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_idx    <= '0;
                        diff     <= '0;
                        bout     <= 1'b0;
                        ovf      <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    diff[{r_idx, 2'b00} +: 4] <= w_sdiff;
                    r_borrow                  <= w_sbout;
                    if (r_idx == C_LAST) begin
                        // Sign of the result comes from the nibble being
                        // written now, not the stale register content.
                        bout    <= w_sbout;
                        ovf     <= (r_a[C_W-1] != r_b[C_W-1]) &&
                                   (w_sdiff[3] != r_a[C_W-1]);
                        r_idx   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// ============================================================================
// Module      : sub4_bla
// Description : 4-bit borrow-lookahead subtractor slice, Diff = X - Y - Bin.
//               Generate: X=0,Y=1 borrows unconditionally.
//               Propagate: X==Y passes the incoming borrow through.
// Ports       : X, Y  - 4-bit operands; Bin - borrow in
//               Diff  - 4-bit difference; Bout - borrow out
// Revision    : 1.0 - initial release
// ============================================================================
module sub4_bla (
    output logic [3:0] Diff,
    output logic       Bout,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       Bin
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_b;

    assign w_g = ~X & Y;
    assign w_p = ~(X ^ Y);

    // Flattened lookahead: every borrow depends only on g, p and Bin.
    assign w_b[0] = Bin;
    assign w_b[1] = w_g[0] | (w_p[0] & Bin);
    assign w_b[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Bin);
    assign w_b[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) |
                    (w_p[2] & w_p[1] & w_p[0] & Bin);
    assign w_b[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) |
                    (w_p[3] & w_p[2] & w_p[1] & w_g[0]) |
                    (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Bin);

    assign Diff = X ^ Y ^ w_b[3:0];
    assign Bout = w_b[4];

endmodule
`default_nettype wire
